pc_fetch_unit: RTL
==================

Name: pc_fetch_unit

Overview:
- Program-counter stage of the single-cycle MIPS core, directly upstream of the instruction decoder/controller.
- Holds PC and computes next-PC from the controller's PCSrc encoding plus branch/jump/jr operands.
- Synchronises the external interrupt line and arbitrates interrupt entry. It drives the IRQ input of the controller, which forces the $26 write of PC+4.
- Bit 31 of PC is the kernel-mode flag.

Parameters:
RESET_VEC, 32'h8000_0000, PC after reset (kernel mode)
IRQ_VEC, 32'h8000_0004, interrupt entry address
EXC_VEC, 32'h8000_0008, exception entry address (used only with the optional feature)
SYNC_STAGES, 2, flip-flop depth of the irq_in synchroniser (≥2)

Ports:
clk  in  1  core clock, all state on rising edge
reset  in  1  synchronous, active-high; one clock; polarity and synchronicity fixed
en  in  1  advance enable; 0 = stall
pc_src  in  2  00 seq, 01 branch, 10 j/jal, 11 jr/jalr
branch_taken  in  1  ALU branch condition, sampled only when pc_src=01
imm16  in  16  branch offset, sign-extended internally
jtarget  in  26  J-format target field
jr_addr  in  32  rs register value for jr/jalr
irq_in  in  1  asynchronous level from timer/peripheral
pc  out  32  current PC
pc_plus4  out  32  pc+4, combinational
irq_take  out  1  combinational; to controller IRQ input
kernel  out  1  = pc[31]
align_exc  out  1  misaligned-jr pulse; constant 0 without the optional feature

Behaviour:
- Reset: pc=RESET_VEC; synchroniser flops=0; irq_pending=0; outputs follow pc (irq_take=0, align_exc=0). Reset asserted mid-operation discards pending interrupt and any stall.
- irq_in passes SYNC_STAGES flops, then a rising-edge detector. A detected edge sets irq_pending; the level alone never re-sets it.
- irq_take = irq_pending & ~pc[31] & en. No nesting: interrupts are held pending while in kernel mode.
- Next-PC when en=1, with priority irq_take > pc_src:
  - irq_take: IRQ_VEC; irq_pending cleared.
  - 00: pc_plus4.
  - 01: branch_taken ? pc_plus4 + (sext(imm16)<<2) : pc_plus4.
  - 10: {pc_plus4[31:28], jtarget, 2'b00}.
  - 11: {jr_addr[31] & pc[31], jr_addr[30:2], 2'b00}. User code cannot enter kernel via jr; kernel jr to a user address exits kernel.
  - pc_src 01/10 never changes bit 31 except via pc_plus4 carry, which is ignored: bit 31 of the result is forced to pc[31].
- All 32-bit arithmetic wraps modulo 2^32. PC[1:0] always 00.
- en=0: pc frozen; irq_take=0; irq_pending retained; synchroniser and edge detector keep running, so edges during a stall are not lost.
- Edge detected in the same cycle as a take: set wins, and pending remains 1 for the next interrupt.
- Multiple edges while pending collapse into one interrupt.
- Latency: irq_in rise to irq_take is SYNC_STAGES+1 cycles in user mode.

Optional Feature:
PC_ALIGN_EXC_EN.
- Defined: pc_src=11 with jr_addr[1:0]≠0 and no irq_take gives next pc=EXC_VEC, with align_exc=1 combinationally that cycle (en=1). IRQ still has priority.
- Undefined: low bits are silently masked and align_exc is tied 0.

Decomposition:
- Shared package (core-wide): RESET_VEC/IRQ_VEC/EXC_VEC defaults; PCSrc encoding constants PCSRC_SEQ/BRANCH/JUMP/JR (shared with the controller); KERNEL_BIT=31.
- One sub-module: irq_sync_edge (SYNC_STAGES-flop synchroniser plus rising-edge pulse, synchronous reset).

Test Plan:
- Reset asserted 3 cycles -> pc=0x8000_0000, kernel=1, irq_take=0, pc_plus4=0x8000_0004.
- User pc=0x0000_0100, pc_src=01, imm16=0xFFFE: taken -> 0x0000_00FC; not taken -> 0x0000_0104. pc=0x0040_0000, pc_src=10, jtarget=0x40 -> 0x0000_0100.
- User pc=0x100, jr_addr=0x8000_0010 -> 0x0000_0010. Kernel pc=0x8000_0020, jr_addr=0x0000_0204 -> 0x0000_0204, kernel=0.
- irq_in rises at user pc=0x200:
  - irq_take=1 exactly 3 cycles later, then pc=0x8000_0004.
  - A second edge inside the ISR gives no take until jr to 0x0000_0204.
  - The take occurs the first user cycle after that jr.
- Pending IRQ with en=0 for 5 cycles -> pc constant, irq_take=0. en=1 -> take in that cycle.
- jr_addr=0x0000_0102 from user: with PC_ALIGN_EXC_EN -> pc=0x8000_0008, align_exc=1. Without it -> pc=0x0000_0100, align_exc=0.

Source files
------------

// File: rtl/pc_fetch_unit_pkg.sv
// Core-wide constants shared by the fetch stage and the controller: vectors, PCSrc encoding,
// kernel-mode bit position and the branch-offset helper.
package pc_fetch_unit_pkg;

    localparam logic [31:0] RESET_VEC_DFLT   = 32'h8000_0000;
    localparam logic [31:0] IRQ_VEC_DFLT     = 32'h8000_0004;
    localparam logic [31:0] EXC_VEC_DFLT     = 32'h8000_0008;
    localparam int          SYNC_STAGES_DFLT = 2;

    localparam int          KERNEL_BIT       = 31;

    typedef enum logic [1:0] {
        PCSRC_SEQ    = 2'b00,
        PCSRC_BRANCH = 2'b01,
        PCSRC_JUMP   = 2'b10,
        PCSRC_JR     = 2'b11
    } pcsrc_e;

    // Word offset of a conditional branch, as a byte displacement.
    function automatic logic [31:0] branch_offset(input logic [15:0] imm16);
        return {{14{imm16[15]}}, imm16, 2'b00};
    endfunction

endpackage

// File: rtl/pc_fetch_unit_irq_sync_edge.sv
// Multi-flop synchroniser for an asynchronous level, followed by a single-cycle rising-edge pulse.
// The pulse is combinational from the last two synchronised samples.
module irq_sync_edge
    import pc_fetch_unit_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DFLT
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_async,
    output logic o_rise
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_rise = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/pc_fetch_unit.sv
// Program-counter stage: PC register, next-PC selection, interrupt synchronisation and entry.
// Optional misaligned-jr exception is enabled by defining PC_ALIGN_EXC_EN.
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_VEC   = RESET_VEC_DFLT,
    parameter logic [31:0] IRQ_VEC     = IRQ_VEC_DFLT,
    parameter logic [31:0] EXC_VEC     = EXC_VEC_DFLT,
    parameter int          SYNC_STAGES = SYNC_STAGES_DFLT
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_en,
    input  logic [1:0]  i_pc_src,
    input  logic        i_branch_taken,
    input  logic [15:0] i_imm16,
    input  logic [25:0] i_jtarget,
    input  logic [31:0] i_jr_addr,
    input  logic        i_irq_in,
    output logic [31:0] o_pc,
    output logic [31:0] o_pc_plus4,
    output logic        o_irq_take,
    output logic        o_kernel,
    output logic        o_align_exc
);

    logic [31:0] r_pc;
    logic        r_irq_pending;

    pcsrc_e      w_pc_src;
    logic        w_kernel;
    logic        w_irq_edge;
    logic        w_irq_take;
    logic        w_align_exc;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_branch_sum;
    logic [31:0] w_branch_tgt;
    logic [31:0] w_jump_tgt;
    logic [31:0] w_jr_tgt;
    logic [31:0] w_next_pc;

    irq_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_irq_sync (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_async (i_irq_in),
        .o_rise  (w_irq_edge)
    );

    assign w_pc_src   = pcsrc_e'(i_pc_src);
    assign w_kernel   = r_pc[KERNEL_BIT];
    assign w_pc_plus4 = r_pc + 32'd4;

    // Interrupts never nest: a pending request waits until the PC is back in user space.
    assign w_irq_take = r_irq_pending & ~w_kernel & i_en;

    // Branch and jump targets keep the current mode bit; any carry into bit 31 is dropped.
    assign w_branch_sum = w_pc_plus4 + branch_offset(i_imm16);
    assign w_branch_tgt = {w_kernel, (i_branch_taken ? w_branch_sum[30:0] : w_pc_plus4[30:0])};
    assign w_jump_tgt   = {w_kernel, w_pc_plus4[30:28], i_jtarget, 2'b00};
    assign w_jr_tgt     = {i_jr_addr[31] & w_kernel, i_jr_addr[30:2], 2'b00};

`ifdef PC_ALIGN_EXC_EN
    assign w_align_exc = i_en & ~w_irq_take & (w_pc_src == PCSRC_JR) & (|i_jr_addr[1:0]);
`else
    logic w_unused_jr_low;
    assign w_align_exc     = 1'b0;
    assign w_unused_jr_low = ^i_jr_addr[1:0];
`endif

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        w_next_pc = r_pc;
        if (i_en) begin
            if (w_irq_take) begin
                w_next_pc = IRQ_VEC;
            end else if (w_align_exc) begin
                w_next_pc = EXC_VEC;
            end else begin
                case (w_pc_src)
                    PCSRC_SEQ:    w_next_pc = w_pc_plus4;
                    PCSRC_BRANCH: w_next_pc = w_branch_tgt;
                    PCSRC_JUMP:   w_next_pc = w_jump_tgt;
                    PCSRC_JR:     w_next_pc = w_jr_tgt;
                    default:      w_next_pc = w_pc_plus4;
                endcase
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pc <= RESET_VEC;
        end else begin
            r_pc <= w_next_pc;
        end
    end

    // A new edge outranks the clear, so an edge coinciding with a take stays pending.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_irq_pending <= 1'b0;
        end else if (w_irq_edge) begin
            r_irq_pending <= 1'b1;
        end else if (w_irq_take) begin
            r_irq_pending <= 1'b0;
        end
    end

    assign o_pc        = r_pc;
    assign o_pc_plus4  = w_pc_plus4;
    assign o_irq_take  = w_irq_take;
    assign o_kernel    = w_kernel;
    assign o_align_exc = w_align_exc;

endmodule
